sequence_step_player: RTL and testbench
=======================================

Name: sequence_step_player

Overview:
- Consumes the 32-bit step counter from the sequence stepper and plays one sequence-LUT entry per step.
- Per-step DAC offset values and channel-enable flags are read from a BRAM and drive the DAC mixing stage.
- Tracks the position inside the sequence and the number of completed periods, and raises done after the configured repetitions.
- Sits between the stepper (upstream) and the DAC offset/enable logic (downstream).

Parameters:
- NUM_CH, 2, number of DAC channels per LUT entry
- VAL_W, 16, width of one signed offset value
- ADDR_W, 12, LUT address width (max 4096 entries)

Ports:
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- step_counter  in  32  current step from the stepper
- enable  in  1  level; 1 = play sequence, 0 = stop/idle
- num_steps  in  ADDR_W+1  entries per sequence period; sampled at start
- repetitions  in  16  periods to play; 0 = infinite; sampled at start
- bram_addr  out  ADDR_W  LUT read address (registered)
- bram_rdata  in  NUM_CH*(VAL_W+1)  entry: values in low NUM_CH*VAL_W bits, enables in top NUM_CH bits; 1-cycle read latency
- seq_values  out  NUM_CH*VAL_W  current offsets, channel 0 in LSBs
- seq_enables  out  NUM_CH  current channel enables
- out_valid  out  1  one-cycle pulse when seq_values/seq_enables change to a new entry
- seq_index  out  ADDR_W  index of the entry currently on the outputs
- period_count  out  16  completed periods
- seq_active  out  1  high in PRIME and RUN
- seq_done  out  1  high in DONE
- step_error  out  1  sticky step-anomaly flag
- cfg_error  out  1  high while enable=1 and the sampled num_steps=0

Behaviour:
- Reset: all outputs 0, FSM IDLE, bram_addr 0.
- States: IDLE, PRIME, RUN, DONE.
- IDLE, enable=1, num_steps!=0:
  - Shadow num_steps and repetitions; last_step<=step_counter.
  - index<=0, bram_addr<=0, period_count<=0.
  - Clear step_error; go PRIME.
- IDLE, enable=1, num_steps=0: stay IDLE, cfg_error=1.
- PRIME:
  - Wait 2 cycles for entry 0; load outputs, seq_index=0, pulse out_valid; go RUN.
  - Step changes during PRIME are not consumed and are handled on entering RUN.
- RUN, step advance detected (step_counter != last_step at edge E0):
  - E0: last_step<=step_counter; next index = index+1, wrapping to 0 after num_steps-1; bram_addr<=next index.
  - E1: bram_rdata registered.
  - E2: seq_values, seq_enables and seq_index updated; out_valid pulses. Latency is 2 clocks from the sampling edge.
  - Back-to-back steps on consecutive cycles are fully pipelined: one entry per cycle.
- Wrap (index num_steps-1 -> 0): period_count increments at E0.
  - If repetitions!=0 and the new period_count==repetitions: go DONE at E0; the wrapped entry is not output.
- step_counter - last_step > 1 (unsigned, 32-bit wrap-aware): step_error<=1; advance exactly one entry.
- step_counter < last_step (upstream reset): abort to IDLE; step_error<=1.
- DONE:
  - seq_values and seq_enables forced to 0 on the entry edge; seq_done=1; further steps ignored.
  - Leave to IDLE only when enable=0.
- enable=0 in PRIME/RUN/DONE: IDLE at the next edge.
  - seq_values, seq_enables, seq_active and seq_done go to 0 on the same edge; in-flight reads are discarded.
- num_steps=1: every step outputs entry 0 with out_valid, and period_count increments on every step.
- Changing num_steps or repetitions mid-run has no effect until the next start.
- aresetn low in any state overrides everything: reset values at the next edge.

Decomposition:
- Shared package sequence_pkg:
  - state enum {IDLE, PRIME, RUN, DONE}
  - defaults for VAL_W and ADDR_W
  - localparams for the LUT word layout (value and enable field offsets)
- One sub-module, sequence_index_counter:
  - index increment/wrap, period_count increment, repetition-reached compare
  - output: wrap strobe plus done strobe

Test Plan:
- num_steps=4, repetitions=2, LUT[i] = values i*100, enables 2'b01; enable=1, then step_counter 10->11->...->18, one step per 8 clk -> outputs entries 0,1,2,3,0,1,2,3 each 2 clk after the step; period_count reaches 2 at step 18; seq_done=1, values 0.
- repetitions=0, num_steps=3, 10 steps one per cycle -> out_valid every cycle, seq_index 0,1,2,0,1,2,0,1,2,0,1; period_count=3; never done.
- step_counter jumps 20->23 in RUN -> step_error=1, index advances by exactly 1; cleared on the next start.
- step_counter drops 50->0 in RUN -> IDLE next edge, outputs 0, step_error=1.
- num_steps=0 with enable=1 -> stays IDLE, cfg_error=1, no out_valid; set num_steps=5 -> PRIME, entry 0 after 2 clk.
- enable deasserted one cycle after a step advance -> IDLE next edge; no out_valid for the in-flight entry; outputs 0.

Source files
------------

// File: rtl/sequence_pkg.sv
// Shared types and LUT word layout for the sequence step player.
package sequence_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      DONE
   } seq_state_e;

   localparam int DEF_NUM_CH = 2;
   localparam int DEF_VAL_W  = 16;
   localparam int DEF_ADDR_W = 12;

   // Offsets are always 0; the enable flags sit directly above the packed values.
   localparam int VALUE_LSB = 0;

   function automatic int enableLsb(input int numCh, input int valW);
      return numCh * valW;
   endfunction

endpackage

// File: rtl/sequence_index_counter.sv
// Position inside the sequence period and completed-period count,
// with look-ahead wrap/done strobes for the current index.
module sequence_index_counter #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              clear_i,
   input  logic              advance_i,
   input  logic [ADDR_W:0]   numSteps_i,
   input  logic [15:0]       repetitions_i,
   output logic [ADDR_W-1:0] nextIndex_o,
   output logic [15:0]       periodCount_o,
   output logic              wrap_o,
   output logic              done_o
);

   logic [ADDR_W-1:0] index_q, index_d;
   logic [15:0]       periodCount_q, periodCount_d;
   logic [ADDR_W:0]   lastIndex;
   logic [15:0]       periodNext;

   // Strobes describe what would happen if the current index advanced now.
   always_comb begin
      lastIndex   = numSteps_i - (ADDR_W+1)'(1);
      periodNext  = periodCount_q + 16'd1;
      wrap_o      = ({1'b0, index_q} == lastIndex);
      nextIndex_o = wrap_o ? '0 : index_q + ADDR_W'(1);
      done_o      = wrap_o && (repetitions_i != 16'd0) && (periodNext == repetitions_i);

      index_d       = index_q;
      periodCount_d = periodCount_q;
      if (clear_i) begin
         index_d       = '0;
         periodCount_d = '0;
      end else if (advance_i) begin
         index_d = nextIndex_o;
         if (wrap_o) begin
            periodCount_d = periodNext;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         index_q       <= '0;
         periodCount_q <= '0;
      end else begin
         index_q       <= index_d;
         periodCount_q <= periodCount_d;
      end
   end

   assign periodCount_o = periodCount_q;

endmodule

// File: rtl/sequence_step_player.sv
// Plays one LUT entry per upstream step: BRAM address at the step edge,
// data registered by the BRAM, outputs loaded two clocks after the step.
module sequence_step_player
   import sequence_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int VAL_W  = DEF_VAL_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic [31:0]                  step_counter,
   input  logic                         enable,
   input  logic [ADDR_W:0]              num_steps,
   input  logic [15:0]                  repetitions,
   output logic [ADDR_W-1:0]            bram_addr,
   input  logic [NUM_CH*(VAL_W+1)-1:0]  bram_rdata,
   output logic [NUM_CH*VAL_W-1:0]      seq_values,
   output logic [NUM_CH-1:0]            seq_enables,
   output logic                         out_valid,
   output logic [ADDR_W-1:0]            seq_index,
   output logic [15:0]                  period_count,
   output logic                         seq_active,
   output logic                         seq_done,
   output logic                         step_error,
   output logic                         cfg_error
);

   localparam int ENABLE_LSB = enableLsb(NUM_CH, VAL_W);

   seq_state_e                state_q, state_d;
   logic [31:0]               lastStep_q, lastStep_d;
   logic [ADDR_W:0]           numSteps_q, numSteps_d;
   logic [15:0]               reps_q, reps_d;
   logic [ADDR_W-1:0]         bramAddr_q, bramAddr_d;
   logic                      pend1_q, pend1_d, pend2_q, pend2_d;
   logic [ADDR_W-1:0]         idx1_q, idx1_d, idx2_q, idx2_d;
   logic [NUM_CH*VAL_W-1:0]   values_q, values_d;
   logic [NUM_CH-1:0]         enables_q, enables_d;
   logic [ADDR_W-1:0]         seqIndex_q, seqIndex_d;
   logic                      outValid_q, outValid_d;
   logic                      stepError_q, stepError_d;
   logic                      cfgError_q, cfgError_d;

   logic                      cntClear, cntAdvance, cntWrap, cntDone;
   logic [ADDR_W-1:0]         nextIndex;
   logic [31:0]               stepDelta;

   sequence_index_counter #(.ADDR_W(ADDR_W)) uIndexCounter (
      .clk           (clk),
      .aresetn       (aresetn),
      .clear_i       (cntClear),
      .advance_i     (cntAdvance),
      .numSteps_i    (numSteps_q),
      .repetitions_i (reps_q),
      .nextIndex_o   (nextIndex),
      .periodCount_o (period_count),
      .wrap_o        (cntWrap),
      .done_o        (cntDone)
   );

   assign stepDelta = step_counter - lastStep_q;

   always_comb begin
      state_d     = state_q;
      lastStep_d  = lastStep_q;
      numSteps_d  = numSteps_q;
      reps_d      = reps_q;
      bramAddr_d  = bramAddr_q;
      pend1_d     = 1'b0;
      pend2_d     = pend1_q;
      idx1_d      = idx1_q;
      idx2_d      = idx1_q;
      values_d    = values_q;
      enables_d   = enables_q;
      seqIndex_d  = seqIndex_q;
      outValid_d  = 1'b0;
      stepError_d = stepError_q;
      cfgError_d  = 1'b0;
      cntClear    = 1'b0;
      cntAdvance  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               if (num_steps == '0) begin
                  cfgError_d = 1'b1;
               end else begin
                  numSteps_d  = num_steps;
                  reps_d      = repetitions;
                  lastStep_d  = step_counter;
                  bramAddr_d  = '0;
                  idx1_d      = '0;
                  pend1_d     = 1'b1;
                  cntClear    = 1'b1;
                  stepError_d = 1'b0;
                  state_d     = PRIME;
               end
            end
         end

         PRIME, RUN: begin
            if (!enable) begin
               state_d   = IDLE;
               values_d  = '0;
               enables_d = '0;
               pend2_d   = 1'b0;
            end else begin
               if (pend2_q) begin
                  values_d   = bram_rdata[VALUE_LSB +: NUM_CH*VAL_W];
                  enables_d  = bram_rdata[ENABLE_LSB +: NUM_CH];
                  seqIndex_d = idx2_q;
                  outValid_d = 1'b1;
                  if (state_q == PRIME) begin
                     state_d = RUN;
                  end
               end
               // A backwards step means the stepper restarted underneath us.
               if ((state_q == RUN) && (step_counter != lastStep_q)) begin
                  if (step_counter < lastStep_q) begin
                     state_d     = IDLE;
                     stepError_d = 1'b1;
                     values_d    = '0;
                     enables_d   = '0;
                     outValid_d  = 1'b0;
                     pend2_d     = 1'b0;
                  end else begin
                     lastStep_d = step_counter;
                     cntAdvance = 1'b1;
                     if (stepDelta > 32'd1) begin
                        stepError_d = 1'b1;
                     end
                     if (cntDone) begin
                        state_d    = DONE;
                        values_d   = '0;
                        enables_d  = '0;
                        outValid_d = 1'b0;
                        pend2_d    = 1'b0;
                     end else begin
                        bramAddr_d = nextIndex;
                        idx1_d     = nextIndex;
                        pend1_d    = 1'b1;
                     end
                  end
               end
            end
         end

         DONE: begin
            pend2_d = 1'b0;
            if (!enable) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         lastStep_q  <= '0;
         numSteps_q  <= '0;
         reps_q      <= '0;
         bramAddr_q  <= '0;
         pend1_q     <= 1'b0;
         pend2_q     <= 1'b0;
         idx1_q      <= '0;
         idx2_q      <= '0;
         values_q    <= '0;
         enables_q   <= '0;
         seqIndex_q  <= '0;
         outValid_q  <= 1'b0;
         stepError_q <= 1'b0;
         cfgError_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastStep_q  <= lastStep_d;
         numSteps_q  <= numSteps_d;
         reps_q      <= reps_d;
         bramAddr_q  <= bramAddr_d;
         pend1_q     <= pend1_d;
         pend2_q     <= pend2_d;
         idx1_q      <= idx1_d;
         idx2_q      <= idx2_d;
         values_q    <= values_d;
         enables_q   <= enables_d;
         seqIndex_q  <= seqIndex_d;
         outValid_q  <= outValid_d;
         stepError_q <= stepError_d;
         cfgError_q  <= cfgError_d;
      end
   end

   assign bram_addr   = bramAddr_q;
   assign seq_values  = values_q;
   assign seq_enables = enables_q;
   assign out_valid   = outValid_q;
   assign seq_index   = seqIndex_q;
   assign seq_active  = (state_q == PRIME) || (state_q == RUN);
   assign seq_done    = (state_q == DONE);
   assign step_error  = stepError_q;
   assign cfg_error   = cfgError_q;

   logic unusedWrap;
   assign unusedWrap = cntWrap;

endmodule

// File: tb/tb_sequence_step_player.sv
// Directed bench for sequence_step_player with a 1-cycle-latency BRAM model.
module tb_sequence_step_player;

   localparam int NUM_CH = 2;
   localparam int VAL_W  = 16;
   localparam int ADDR_W = 12;

   logic                        clk;
   logic                        aresetn;
   logic [31:0]                 step_counter;
   logic                        enable;
   logic [ADDR_W:0]             num_steps;
   logic [15:0]                 repetitions;
   logic [ADDR_W-1:0]           bram_addr;
   logic [NUM_CH*(VAL_W+1)-1:0] bram_rdata;
   logic [NUM_CH*VAL_W-1:0]     seq_values;
   logic [NUM_CH-1:0]           seq_enables;
   logic                        out_valid;
   logic [ADDR_W-1:0]           seq_index;
   logic [15:0]                 period_count;
   logic                        seq_active;
   logic                        seq_done;
   logic                        step_error;
   logic                        cfg_error;

   int checks = 0;
   int errors = 0;

   logic [NUM_CH*(VAL_W+1)-1:0] lut [0:(1<<ADDR_W)-1];

   sequence_step_player #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .step_counter (step_counter),
      .enable       (enable),
      .num_steps    (num_steps),
      .repetitions  (repetitions),
      .bram_addr    (bram_addr),
      .bram_rdata   (bram_rdata),
      .seq_values   (seq_values),
      .seq_enables  (seq_enables),
      .out_valid    (out_valid),
      .seq_index    (seq_index),
      .period_count (period_count),
      .seq_active   (seq_active),
      .seq_done     (seq_done),
      .step_error   (step_error),
      .cfg_error    (cfg_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read BRAM: address sampled at the edge, data valid after it.
   always @(posedge clk) begin
      bram_rdata <= lut[bram_addr];
   end

   function automatic logic [NUM_CH*VAL_W-1:0] expVal(input int idx);
      return {16'(idx*100 + 1), 16'(idx*100)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      aresetn = 1'b0; enable = 1'b1; num_steps = '0; repetitions = '0; step_counter = '0;
      tick; tick; tick;
      checks++;
      if ({out_valid, seq_active, seq_done, step_error, cfg_error} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {out_valid, seq_active, seq_done, step_error, cfg_error});
      end
      checks++;
      if ({seq_values, seq_enables, seq_index, period_count, bram_addr} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: values %h enables %b index %0d period %0d addr %0d expected all 0",
                  seq_values, seq_enables, seq_index, period_count, bram_addr);
      end
      enable = 1'b0;
      aresetn = 1'b1;
      tick;
   endtask

   task automatic test_periodic;
      num_steps = 13'd4; repetitions = 16'd2; step_counter = 32'd10; enable = 1'b1;
      tick;
      checks++;
      if (seq_active !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL prime_enter: active %b valid %b expected 1 0", seq_active, out_valid);
      end
      tick; tick;
      checks++;
      if (out_valid !== 1'b1 || seq_index !== 12'd0 || seq_values !== expVal(0) || seq_enables !== 2'b01) begin
         errors++;
         $display("[TB] FAIL prime_entry0: valid %b index %0d values %h enables %b expected 1 0 %h 01",
                  out_valid, seq_index, seq_values, expVal(0), seq_enables);
      end
      for (int s = 11; s <= 17; s++) begin
         step_counter = 32'(s);
         tick; tick;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step%0d_latency: valid %b expected 0 before second edge", s, out_valid);
         end
         tick;
         checks++;
         if (out_valid !== 1'b1 || seq_index !== 12'((s-10) % 4) || seq_values !== expVal((s-10) % 4)
             || seq_enables !== 2'b01) begin
            errors++;
            $display("[TB] FAIL step%0d_entry: valid %b index %0d values %h expected 1 %0d %h",
                     s, out_valid, seq_index, seq_values, (s-10) % 4, expVal((s-10) % 4));
         end
         if (s == 14) begin
            checks++;
            if (period_count !== 16'd1) begin
               errors++;
               $display("[TB] FAIL first_wrap_period: got %0d expected 1", period_count);
            end
         end
         tick; tick; tick; tick; tick;
      end
      step_counter = 32'd18;
      tick;
      checks++;
      if (seq_done !== 1'b1 || seq_active !== 1'b0 || seq_values !== '0 || seq_enables !== '0 || period_count !== 16'd2) begin
         errors++;
         $display("[TB] FAIL done_entry: done %b active %b values %h enables %b period %0d expected 1 0 0 0 2",
                  seq_done, seq_active, seq_values, seq_enables, period_count);
      end
      begin
         int pulses = 0;
         step_counter = 32'd19;
         for (int i = 0; i < 4; i++) begin
            tick;
            if (out_valid) pulses++;
         end
         checks++;
         if (pulses != 0 || seq_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_hold: pulses %0d done %b expected 0 1", pulses, seq_done);
         end
      end
      enable = 1'b0;
      tick;
      checks++;
      if (seq_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_leave: done %b expected 0", seq_done);
      end
   endtask

   task automatic test_back_to_back;
      num_steps = 13'd3; repetitions = 16'd0; step_counter = 32'd100; enable = 1'b1;
      tick; tick; tick;
      checks++;
      if (out_valid !== 1'b1 || seq_index !== 12'd0) begin
         errors++;
         $display("[TB] FAIL b2b_prime: valid %b index %0d expected 1 0", out_valid, seq_index);
      end
      for (int k = 1; k <= 12; k++) begin
         if (k <= 10) step_counter = 32'(100 + k);
         tick;
         checks++;
         if (k < 3) begin
            if (out_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_gap%0d: valid %b expected 0", k, out_valid);
            end
         end else if (out_valid !== 1'b1 || seq_index !== 12'((k-2) % 3) || seq_values !== expVal((k-2) % 3)) begin
            errors++;
            $display("[TB] FAIL b2b_out%0d: valid %b index %0d values %h expected 1 %0d %h",
                     k, out_valid, seq_index, seq_values, (k-2) % 3, expVal((k-2) % 3));
         end
      end
      tick;
      checks++;
      if (period_count !== 16'd3 || seq_done !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_end: period %0d done %b valid %b expected 3 0 0", period_count, seq_done, out_valid);
      end
      enable = 1'b0;
      tick;
   endtask

   task automatic test_step_jump;
      num_steps = 13'd4; repetitions = 16'd0; step_counter = 32'd20; enable = 1'b1;
      tick; tick; tick;
      step_counter = 32'd21;
      tick; tick; tick;
      checks++;
      if (seq_index !== 12'd1 || step_error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL jump_pre: index %0d error %b expected 1 0", seq_index, step_error);
      end
      step_counter = 32'd23;
      tick; tick; tick;
      checks++;
      if (out_valid !== 1'b1 || seq_index !== 12'd2 || step_error !== 1'b1) begin
         errors++;
         $display("[TB] FAIL jump_advance: valid %b index %0d error %b expected 1 2 1", out_valid, seq_index, step_error);
      end
      enable = 1'b0;
      tick;
      checks++;
      if (step_error !== 1'b1) begin
         errors++;
         $display("[TB] FAIL jump_sticky: error %b expected 1", step_error);
      end
      step_counter = 32'd50; enable = 1'b1;
      tick;
      checks++;
      if (step_error !== 1'b0 || seq_active !== 1'b1) begin
         errors++;
         $display("[TB] FAIL jump_clear: error %b active %b expected 0 1", step_error, seq_active);
      end
   endtask

   task automatic test_step_drop;
      tick; tick;
      checks++;
      if (out_valid !== 1'b1 || seq_values !== expVal(0)) begin
         errors++;
         $display("[TB] FAIL drop_prime: valid %b values %h expected 1 %h", out_valid, seq_values, expVal(0));
      end
      step_counter = 32'd0;
      tick;
      checks++;
      if (seq_active !== 1'b0 || seq_values !== '0 || seq_enables !== '0 || step_error !== 1'b1) begin
         errors++;
         $display("[TB] FAIL drop_abort: active %b values %h enables %b error %b expected 0 0 0 1",
                  seq_active, seq_values, seq_enables, step_error);
      end
      enable = 1'b0;
      tick;
   endtask

   task automatic test_cfg_error;
      int pulses = 0;
      num_steps = '0; repetitions = 16'd0; enable = 1'b1;
      tick;
      checks++;
      if (cfg_error !== 1'b1 || seq_active !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cfg_flag: cfg %b active %b expected 1 0", cfg_error, seq_active);
      end
      for (int i = 0; i < 3; i++) begin
         tick;
         if (out_valid || seq_active) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL cfg_idle: activity %0d expected 0", pulses);
      end
      num_steps = 13'd5;
      tick;
      checks++;
      if (cfg_error !== 1'b0 || seq_active !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cfg_start: cfg %b active %b expected 0 1", cfg_error, seq_active);
      end
      tick; tick;
      checks++;
      if (out_valid !== 1'b1 || seq_index !== 12'd0 || seq_values !== expVal(0)) begin
         errors++;
         $display("[TB] FAIL cfg_entry0: valid %b index %0d values %h expected 1 0 %h", out_valid, seq_index, seq_values, expVal(0));
      end
   endtask

   task automatic test_disable_inflight;
      int pulses = 0;
      step_counter = 32'd1;
      tick;
      enable = 1'b0;
      tick;
      checks++;
      if (seq_active !== 1'b0 || seq_values !== '0 || seq_enables !== '0) begin
         errors++;
         $display("[TB] FAIL disable_idle: active %b values %h enables %b expected 0 0 0", seq_active, seq_values, seq_enables);
      end
      for (int i = 0; i < 3; i++) begin
         tick;
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL disable_inflight: pulses %0d expected 0", pulses);
      end
   endtask

   task automatic test_single_entry;
      num_steps = 13'd1; repetitions = 16'd0; step_counter = 32'd5; enable = 1'b1;
      tick; tick; tick;
      for (int s = 6; s <= 7; s++) begin
         step_counter = 32'(s);
         tick; tick; tick;
         checks++;
         if (out_valid !== 1'b1 || seq_index !== 12'd0 || seq_values !== expVal(0) || period_count !== 16'(s - 5)) begin
            errors++;
            $display("[TB] FAIL single_step%0d: valid %b index %0d values %h period %0d expected 1 0 %h %0d",
                     s, out_valid, seq_index, seq_values, period_count, expVal(0), s - 5);
         end
      end
      aresetn = 1'b0;
      tick;
      checks++;
      if (period_count !== 16'd0 || seq_active !== 1'b0 || seq_values !== '0 || bram_addr !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_reset: period %0d active %b values %h addr %0d expected 0 0 0 0",
                  period_count, seq_active, seq_values, bram_addr);
      end
      aresetn = 1'b1;
      enable = 1'b0;
      tick;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         lut[i] = {2'b01, 16'(i*100 + 1), 16'(i*100)};
      end
      test_reset;
      test_periodic;
      test_back_to_back;
      test_step_jump;
      test_step_drop;
      test_cfg_error;
      test_disable_inflight;
      test_single_entry;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
